// File: rtl/operand_fwd_stage.sv
// rtl/operand_fwd_stage.sv - operand forwarding select with registered valid/ready output slot (optional FWD_STATS_EN counters)
module operand_fwd_stage #(
    parameter int WIDTH   = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_SRC = 2,
    parameter int SEL_W   = $clog2(NUM_SRC + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [ADDR_W-1:0]          rs_addr_i,
    input  logic [WIDTH-1:0]           rf_data_i,
    input  logic [NUM_SRC-1:0]         src_wen_i,
    input  logic [NUM_SRC*ADDR_W-1:0]  src_addr_i,
    input  logic [NUM_SRC*WIDTH-1:0]   src_data_i,
    input  logic [NUM_SRC-1:0]         src_ready_i,
    input  logic                       flush_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [WIDTH-1:0]           data_o,
    output logic [SEL_W-1:0]           fwd_sel_o,
    output logic                       hazard_o
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]                fwd_cnt_o,
    output logic [31:0]                stall_cnt_o
`endif
);

    logic [NUM_SRC-1:0] match;
    logic               hit;
    logic               win_ready;
    logic [WIDTH-1:0]   sel_data;
    logic [SEL_W-1:0]   sel_code;
    logic               accept;

    always_comb begin
        for (int k = 0; k < NUM_SRC; k++) begin
            match[k] = src_wen_i[k]
                    && (src_addr_i[k*ADDR_W +: ADDR_W] == rs_addr_i)
                    && (rs_addr_i != '0);
        end
    end

    // Walk from oldest to youngest so the youngest match overwrites; a
    // not-ready young match therefore shadows any older ready one.
    always_comb begin
        hit       = 1'b0;
        win_ready = 1'b1;
        sel_data  = rf_data_i;
        sel_code  = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (match[k]) begin
                hit       = 1'b1;
                win_ready = src_ready_i[k];
                sel_data  = src_data_i[k*WIDTH +: WIDTH];
                sel_code  = SEL_W'(k + 1);
            end
        end
    end

    assign hazard_o   = in_valid_i && hit && !win_ready;
    assign in_ready_o = (!out_valid_o || out_ready_i) && !hazard_o;
    assign accept     = in_valid_i && in_ready_o && !flush_i;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            out_valid_o <= 1'b0;
            data_o      <= '0;
            fwd_sel_o   <= '0;
        end else if (flush_i) begin
            out_valid_o <= 1'b0;
        end else if (accept) begin
            out_valid_o <= 1'b1;
            data_o      <= sel_data;
            fwd_sel_o   <= sel_code;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

`ifdef FWD_STATS_EN
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            fwd_cnt_o   <= '0;
            stall_cnt_o <= '0;
        end else begin
            if (accept && (sel_code != '0) && (fwd_cnt_o != 32'hFFFF_FFFF))
                fwd_cnt_o <= fwd_cnt_o + 32'd1;
            if (hazard_o && (stall_cnt_o != 32'hFFFF_FFFF))
                stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_operand_fwd_stage.sv
// tb/tb_operand_fwd_stage.sv - directed self-checking bench for operand_fwd_stage
module tb_operand_fwd_stage;

    localparam int WIDTH   = 32;
    localparam int ADDR_W  = 5;
    localparam int NUM_SRC = 2;
    localparam int SEL_W   = $clog2(NUM_SRC + 1);

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic                      in_valid = 1'b0;
    logic                      in_ready;
    logic [ADDR_W-1:0]         rs_addr = '0;
    logic [WIDTH-1:0]          rf_data = '0;
    logic [NUM_SRC-1:0]        src_wen = '0;
    logic [NUM_SRC*ADDR_W-1:0] src_addr = '0;
    logic [NUM_SRC*WIDTH-1:0]  src_data = '0;
    logic [NUM_SRC-1:0]        src_ready = '0;
    logic                      flush = 1'b0;
    logic                      out_valid;
    logic                      out_ready = 1'b1;
    logic [WIDTH-1:0]          data;
    logic [SEL_W-1:0]          fwd_sel;
    logic                      hazard;
`ifdef FWD_STATS_EN
    logic [31:0]               fwd_cnt;
    logic [31:0]               stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    operand_fwd_stage #(
        .WIDTH(WIDTH), .ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .rs_addr_i(rs_addr), .rf_data_i(rf_data),
        .src_wen_i(src_wen), .src_addr_i(src_addr),
        .src_data_i(src_data), .src_ready_i(src_ready),
        .flush_i(flush),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .data_o(data), .fwd_sel_o(fwd_sel), .hazard_o(hazard)
`ifdef FWD_STATS_EN
        ,
        .fwd_cnt_o(fwd_cnt), .stall_cnt_o(stall_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        // reset
        tick();
        tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", data, 32'd0);
        check("rst_sel", 32'(fwd_sel), 32'd0);
        rst = 1'b1;

        // both producers match: youngest wins
        in_valid = 1'b1; rs_addr = 5; rf_data = 32'h1111;
        src_wen = 2'b11; src_addr = {5'd5, 5'd5};
        src_data = {32'hBBBB, 32'hAAAA}; src_ready = 2'b11;
        settle();
        check("t1_hazard", 32'(hazard), 32'd0);
        check("t1_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("t1_data", data, 32'hAAAA);
        check("t1_sel", 32'(fwd_sel), 32'd1);
        check("t1_valid", 32'(out_valid), 32'd1);

        // only older producer matches, back-to-back accept
        src_addr = {5'd5, 5'd3};
        tick();
        check("t2_data", data, 32'hBBBB);
        check("t2_sel", 32'(fwd_sel), 32'd2);

        // x0 never forwards
        rs_addr = 0; src_addr = {5'd0, 5'd0}; rf_data = 32'h0;
        tick();
        check("x0_data", data, 32'h0);
        check("x0_sel", 32'(fwd_sel), 32'd0);

        // no match -> register file
        rs_addr = 9; rf_data = 32'hCAFE;
        tick();
        check("rf_data", data, 32'hCAFE);
        check("rf_sel", 32'(fwd_sel), 32'd0);

        // load-use: young not-ready match blocks older ready match
        rs_addr = 7; src_addr = {5'd7, 5'd7};
        src_data = {32'h5555, 32'h0}; src_ready = 2'b10;
        in_valid = 1'b0;
        settle();
        check("hz_idle", 32'(hazard), 32'd0);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("hz_hazard", 32'(hazard), 32'd1);
            check("hz_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        check("hz_drained", 32'(out_valid), 32'd0);
`ifdef FWD_STATS_EN
        check("hz_stall_cnt", stall_cnt, 32'd3);
`endif
        src_ready = 2'b11; src_data = {32'h5555, 32'h1234};
        settle();
        check("hz_resolved", 32'(in_ready), 32'd1);
        tick();
        check("hz_data", data, 32'h1234);
        check("hz_sel", 32'(fwd_sel), 32'd1);
        check("hz_valid", 32'(out_valid), 32'd1);

        // backpressure holds the slot while inputs churn
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rs_addr = 5'(10 + i); rf_data = 32'h100 + i;
            settle();
            check("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
            check("bp_data", data, 32'h1234);
            check("bp_sel", 32'(fwd_sel), 32'd1);
            check("bp_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1; rs_addr = 9; rf_data = 32'hBEEF;
        settle();
        check("bp_release", 32'(in_ready), 32'd1);
        tick();
        check("bp_next_data", data, 32'hBEEF);
        check("bp_next_sel", 32'(fwd_sel), 32'd0);

        // flush beats accept
        rs_addr = 5; src_addr = {5'd3, 5'd5}; src_data = {32'h0, 32'h7777};
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_valid", 32'(out_valid), 32'd0);
        check("fl_data_hold", data, 32'hBEEF);
`ifdef FWD_STATS_EN
        check("fl_fwd_cnt", fwd_cnt, 32'd3);
`endif

        // accept then consume without accept
        tick();
        check("c_data", data, 32'h7777);
        in_valid = 1'b0;
        tick();
        check("c_valid", 32'(out_valid), 32'd0);
        check("c_data_hold", data, 32'h7777);
        check("c_sel_hold", 32'(fwd_sel), 32'd1);

        // reset mid-backpressure drops the operand
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        check("r_pre_valid", 32'(out_valid), 32'd1);
`ifdef FWD_STATS_EN
        check("r_pre_fwd_cnt", fwd_cnt, 32'd5);
`endif
        rst = 1'b0;
        tick();
        check("r_valid", 32'(out_valid), 32'd0);
        check("r_data", data, 32'd0);
        check("r_sel", 32'(fwd_sel), 32'd0);
`ifdef FWD_STATS_EN
        check("r_fwd_cnt", fwd_cnt, 32'd0);
        check("r_stall_cnt", stall_cnt, 32'd0);
`endif
        rst = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/operand_fwd_stage.md
# operand_fwd_stage

Parametrised operand forwarding stage for the pipelined RISC-V core. It compares one source-register address against NUM_SRC in-flight producers, picks the youngest matching producer or the register-file value, and registers the result into a valid/ready output slot. It also raises a load-use hazard when the winning producer's data is not yet available. One instance sits per operand (rs1, rs2) between ID and EX, replacing the fixed three-input forwarding select.

## Interface
- WIDTH, 32, operand data width
- ADDR_W, 5, register address width
- NUM_SRC, 2, number of forwarding producers (≥1); index 0 = youngest stage
- SEL_W, $clog2(NUM_SRC+1), width of the select code (derived; do not override)

- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  reset, synchronous, active-low
- in_valid_i  input  1  operand request valid
- in_ready_o  output  1  stage accepts request this cycle
- rs_addr_i  input  ADDR_W  source register address
- rf_data_i  input  WIDTH  register-file read value
- src_wen_i  input  NUM_SRC  producer k will write the register file
- src_addr_i  input  NUM_SRC*ADDR_W  producer k destination address, slice [k*ADDR_W +: ADDR_W]
- src_data_i  input  NUM_SRC*WIDTH  producer k result, slice [k*WIDTH +: WIDTH]
- src_ready_i  input  NUM_SRC  producer k result valid (0 = load in flight)
- flush_i  input  1  kill output slot and any capture this cycle
- out_valid_o  output  1  registered operand valid
- out_ready_i  input  1  downstream consumes operand
- data_o  output  WIDTH  registered operand
- fwd_sel_o  output  SEL_W  registered source: 0 = register file, k+1 = producer k
- hazard_o  output  1  combinational; winning match not ready

## Operation
- match[k] = src_wen_i[k] && src_addr_k == rs_addr_i && rs_addr_i != 0. Address 0 never forwards.
- Winner = lowest k with match[k]. No match → rf_data_i, sel 0.
- hazard_o = in_valid_i && winner exists && !src_ready_i[winner]. Younger not-ready match blocks; an older ready match is never used in its place.
- in_ready_o = (!out_valid_o || out_ready_i) && !hazard_o.
- Accept = in_valid_i && in_ready_o && !flush_i. On accept: data_o, fwd_sel_o ← selected value/code, out_valid_o ← 1.
- Consume without accept: out_valid_o ← 0, and data_o/fwd_sel_o hold.
- Backpressure (out_valid_o && !out_ready_i): data_o and fwd_sel_o hold stable.
- flush_i: out_valid_o ← 0 next cycle; flush has priority over accept and over hold.
- No internal FSM beyond the output slot (EMPTY/FULL encoded by out_valid_o).

## Timing
- Latency 1 cycle: request accepted at edge N → data_o valid after edge N.
- Full throughput: back-to-back accepts when out_ready_i=1 every cycle.
- hazard_o and in_ready_o are combinational from inputs and out_valid_o; no path from out_ready_i to data_o.
- Reset (rst_i=0 at edge): out_valid_o=0, data_o=0, fwd_sel_o=0, statistics counters=0. Reset overrides flush and accept. Reset mid-backpressure drops the held operand.
- Hazard resolves the same cycle src_ready_i rises; accept happens at that edge.

## Configuration
- FWD_STATS_EN defined: adds outputs fwd_cnt_o[31:0] (incremented on each accept with nonzero sel) and stall_cnt_o[31:0] (incremented each cycle hazard_o=1). Both saturate at 32'hFFFF_FFFF, clear on reset, and are not cleared by flush.
- FWD_STATS_EN undefined: neither the ports nor the counters exist; all other behaviour is identical.

## Test plan
- NUM_SRC=2, rs=5, src0 addr=5 wen=1 ready=1 data=0xAAAA, src1 addr=5 data=0xBBBB → next cycle data_o=0xAAAA, fwd_sel_o=1, out_valid_o=1.
- rs=0, src0 addr=0 wen=1, rf_data=0x0 → data_o=0, fwd_sel_o=0 (no forward from x0).
- src0 addr=7 ready=0 for 3 cycles, rs=7 → hazard_o=1 and in_ready_o=0 for 3 cycles, stall_cnt_o=3; ready=1 data=0x1234 → accept, data_o=0x1234, sel=1.
- Output full, out_ready_i=0 for 4 cycles with new inputs changing → data_o and fwd_sel_o unchanged, in_ready_o=0; out_ready_i=1 → next operand is loaded the same edge.
- flush_i=1 together with an accept → out_valid_o=0 next cycle and fwd_cnt_o not incremented.
- rst_i=0 while out_valid_o=1 and fwd_cnt_o=9 → after edge all outputs 0 and counters 0.
